// File: rtl/link_credit_tx.sv
// Credit-based internode link transmitter.
// Router flits are buffered in a small FIFO and sent to the link only while downstream
// credit remains. Credit flits arriving on the receive side replenish that credit. All
// other received flits are forwarded to the router.
module link_credit_tx #(
    parameter int unsigned FLIT_SIZE   = 144,
    parameter int unsigned QUEUE_DEPTH = 256,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CREDIT_W    = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] in_flit,
    input  logic                 in_valid,
    output logic                 in_avail,
    output logic [FLIT_SIZE-1:0] tx_flit,
    output logic                 tx_valid,
    input  logic [FLIT_SIZE-1:0] rx_flit,
    input  logic                 rx_valid,
    output logic [FLIT_SIZE-1:0] fwd_flit,
    output logic                 fwd_valid,
    output logic [CREDIT_W-1:0]  credit_count,
    output logic                 overflow,
    output logic                 credit_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // One extra bit so credit plus a returned count cannot wrap before the saturation check.
    localparam int unsigned SumW = CREDIT_W + 1;

    logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [FLIT_SIZE-1:0] tx_flit_q, fwd_flit_q;
    logic                 tx_valid_q, fwd_valid_q;
    logic                 overflow_q, credit_err_q;

    logic                 rx_is_credit;
    logic [CREDIT_W-1:0]  ret_count;
    logic                 fifo_full;
    logic                 pop, push, drop;
    logic [SumW-1:0]      credit_sum;
    logic                 credit_over;

    // Decode FIFO handshakes and compute the next credit value.
    always_comb begin
        rx_is_credit = rx_valid & rx_flit[FLIT_SIZE-1];
        ret_count    = rx_is_credit ? rx_flit[CREDIT_W-1:0] : '0;
        fifo_full    = (count_q == CntW'(FIFO_DEPTH));
        // Pop uses only the current credit, so a credit arriving this cycle first helps next cycle.
        pop          = (count_q != '0) && (credit_q != '0);
        // A full FIFO can still take a flit when the head leaves in the same cycle.
        push         = in_valid && (!fifo_full || pop);
        drop         = in_valid && fifo_full && !pop;
        count_d      = count_q + CntW'(push) - CntW'(pop);
        credit_sum   = SumW'(credit_q) - SumW'(pop) + SumW'(ret_count);
        credit_over  = (credit_sum > SumW'(QUEUE_DEPTH));
        credit_d     = credit_over ? CREDIT_W'(QUEUE_DEPTH) : credit_sum[CREDIT_W-1:0];
    end

    // Report in_avail while at least two entries are free, keeping one entry as slack.
    always_comb begin
        in_avail = (count_q <= CntW'(FIFO_DEPTH - 2));
    end

    // FIFO storage. No reset is needed because reset clears the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

    // Control state: pointers, occupancy, credit, output registers and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credit_q     <= CREDIT_W'(QUEUE_DEPTH);
            tx_flit_q    <= '0;
            tx_valid_q   <= 1'b0;
            fwd_flit_q   <= '0;
            fwd_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PtrW'(1);
                tx_flit_q <= mem_q[rd_ptr_q];
            end
            tx_valid_q <= pop;
            count_q    <= count_d;
            credit_q   <= credit_d;
            // Credit flits are consumed here and are never forwarded.
            fwd_valid_q <= rx_valid && !rx_flit[FLIT_SIZE-1];
            if (rx_valid && !rx_flit[FLIT_SIZE-1]) begin
                fwd_flit_q <= rx_flit;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (credit_over) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    assign tx_flit      = tx_flit_q;
    assign tx_valid     = tx_valid_q;
    assign fwd_flit     = fwd_flit_q;
    assign fwd_valid    = fwd_valid_q;
    assign credit_count = credit_q;
    assign overflow     = overflow_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_link_credit_tx.sv
// Self-checking bench for link_credit_tx. It combines a table of single-cycle vectors,
// hand-written multi-cycle sequences, and a queue scoreboard for transmitted flits.
module tb_link_credit_tx;

    localparam int unsigned FLIT_SIZE   = 144;
    localparam int unsigned QUEUE_DEPTH = 256;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned CREDIT_W    = 9;

    typedef logic [FLIT_SIZE-1:0] flit_t;

    typedef struct {
        logic        in_valid;
        flit_t       in_data;
        logic        rx_valid;
        flit_t       rx_data;
        logic        e_tx;
        logic        e_fwd;
        flit_t       e_fwd_data;
        int unsigned e_credit;
        logic        e_cerr;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    flit_t               in_flit, rx_flit;
    logic                in_valid, rx_valid;
    logic                in_avail;
    flit_t               tx_flit, fwd_flit;
    logic                tx_valid, fwd_valid;
    logic [CREDIT_W-1:0] credit_count;
    logic                overflow, credit_err;

    int    checks   = 0;
    int    failures = 0;
    int    tx_seen  = 0;
    int    t0;
    flit_t exp_q[$];
    flit_t mon_exp;
    vec_t  vecs[6];

    link_credit_tx #(
        .FLIT_SIZE  (FLIT_SIZE),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_avail    (in_avail),
        .tx_flit     (tx_flit),
        .tx_valid    (tx_valid),
        .rx_flit     (rx_flit),
        .rx_valid    (rx_valid),
        .fwd_flit    (fwd_flit),
        .fwd_valid   (fwd_valid),
        .credit_count(credit_count),
        .overflow    (overflow),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transmitted flit must match the oldest expected flit.
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            tx_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0h required=none", tx_flit);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tx_order", tx_flit, mon_exp);
            end
        end
    end

    function automatic flit_t cf(input int unsigned n);
        flit_t f;
        f = '0;
        f[FLIT_SIZE-1] = 1'b1;
        f[CREDIT_W-1:0] = CREDIT_W'(n);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_flit  = '0;
        rx_flit  = '0;
        in_valid = 1'b0;
        rx_valid = 1'b0;

        // Reset held for two cycles.
        tick();
        tick();
        rst = 1'b0;
        chk("rst_credit", credit_count, 32'(QUEUE_DEPTH));
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_in_avail", in_avail, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_credit_err", credit_err, 0);

        // Vector table: cut-through, passthrough, zero credit, and credit saturation.
        vecs[0] = '{1'b1, flit_t'('hA5), 1'b0, '0, 1'b0, 1'b0, '0, 256, 1'b0};
        vecs[1] = '{1'b0, '0, 1'b1, flit_t'('h1234), 1'b1, 1'b1, flit_t'('h1234), 255, 1'b0};
        vecs[2] = '{1'b0, '0, 1'b1, cf(0), 1'b0, 1'b0, '0, 255, 1'b0};
        vecs[3] = '{1'b0, '0, 1'b1, cf(1), 1'b0, 1'b0, '0, 256, 1'b0};
        vecs[4] = '{1'b0, '0, 1'b1, cf(1), 1'b0, 1'b0, '0, 256, 1'b1};
        vecs[5] = '{1'b0, '0, 1'b1, flit_t'('hBEEF), 1'b0, 1'b1, flit_t'('hBEEF), 256, 1'b1};
        for (int i = 0; i < 6; i++) begin
            in_valid = vecs[i].in_valid;
            in_flit  = vecs[i].in_data;
            rx_valid = vecs[i].rx_valid;
            rx_flit  = vecs[i].rx_data;
            if (vecs[i].in_valid) exp_q.push_back(vecs[i].in_data);
            tick();
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].e_tx);
            chk($sformatf("vec%0d_fwd_valid", i), fwd_valid, vecs[i].e_fwd);
            if (vecs[i].e_fwd) chk($sformatf("vec%0d_fwd_flit", i), fwd_flit, vecs[i].e_fwd_data);
            chk($sformatf("vec%0d_credit", i), credit_count, vecs[i].e_credit);
            chk($sformatf("vec%0d_credit_err", i), credit_err, vecs[i].e_cerr);
        end
        idle();

        // Credit exhaustion: 256 flits with no credit returned.
        rst = 1'b1;
        tick();
        exp_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_flit  = flit_t'(i + 1);
            exp_q.push_back(in_flit);
            tick();
        end
        idle();
        tick();
        chk("exhaust_credit", credit_count, 0);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_flit  = flit_t'(32'h1000 + j);
            exp_q.push_back(in_flit);
            tick();
        end
        idle();
        tick();
        tick();
        chk("held_credit", credit_count, 0);
        chk("held_occupancy", dut.count_q, 3);
        chk("held_tx_valid", tx_valid, 0);
        t0 = tx_seen;
        rx_valid = 1'b1;
        rx_flit  = cf(2);
        tick();
        rx_valid = 1'b0;
        chk("ret2_credit", credit_count, 2);
        chk("ret2_no_pop_at_zero", tx_valid, 0);
        chk("ret2_fwd_valid", fwd_valid, 0);
        repeat (4) tick();
        chk("ret2_emitted", tx_seen - t0, 2);
        chk("ret2_credit_after", credit_count, 0);
        chk("ret2_occupancy", dut.count_q, 1);
        chk("ret2_sb_left", exp_q.size(), 1);

        // Pop and credit return in the same cycle, starting from credit 10.
        rx_valid = 1'b1;
        rx_flit  = cf(10);
        tick();
        chk("sim_credit10", credit_count, 10);
        rx_flit = cf(5);
        tick();
        rx_valid = 1'b0;
        chk("sim_credit14", credit_count, 14);
        chk("sim_fwd_valid", fwd_valid, 0);
        chk("sim_tx_valid", tx_valid, 1);
        tick();
        chk("sim_empty", dut.count_q, 0);
        chk("sim_sb_empty", exp_q.size(), 0);

        // Use up the remaining 14 credits, then overflow the FIFO.
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_flit  = flit_t'(32'h2000 + i);
            exp_q.push_back(in_flit);
            tick();
        end
        idle();
        tick();
        tick();
        chk("drain_credit", credit_count, 0);
        chk("drain_empty", dut.count_q, 0);
        for (int k = 1; k <= 9; k++) begin
            in_valid = 1'b1;
            in_flit  = flit_t'(32'h3000 + k);
            if (k <= 8) exp_q.push_back(in_flit);
            tick();
            chk($sformatf("ovf_in_avail_%0d", k), in_avail, (k <= 6));
            chk($sformatf("ovf_flag_%0d", k), overflow, (k == 9));
        end
        idle();
        tick();
        chk("ovf_occupancy", dut.count_q, 8);

        // Return 4 credits, then reset mid-stream with 4 flits still buffered.
        rx_valid = 1'b1;
        rx_flit  = cf(4);
        tick();
        rx_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_occupancy", dut.count_q, 4);
        chk("pre_rst_sb", exp_q.size(), 4);
        t0 = tx_seen;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_flit  = flit_t'('h4444);
        rx_valid = 1'b1;
        rx_flit  = cf(3);
        tick();
        exp_q.delete();
        idle();
        chk("mid_rst_occupancy", dut.count_q, 0);
        chk("mid_rst_credit", credit_count, 32'(QUEUE_DEPTH));
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_tx_flit", tx_flit, 0);
        chk("mid_rst_fwd_flit", fwd_flit, 0);
        tick();
        rst = 1'b0;
        chk("post_rst_in_avail", in_avail, 1);
        repeat (10) tick();
        chk("post_rst_no_tx", tx_seen - t0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
